iob_cache_write_buffer: RTL and testbench

- Write-through buffer sitting directly downstream of the cache front-end.
- Accepts registered write requests (addr, wdata, wstrb) and queues them in a small FIFO.
- Drains the FIFO to the memory back-end over an IOb valid/ready handshake.
- Decouples front-end write acknowledge from back-end memory latency.

---
 rtl/iob_cache_write_buffer_pkg.sv | 18 +
 rtl/iob_cache_wbuf_regfile.sv | 44 ++++
 rtl/iob_cache_write_buffer.sv | 121 ++++++++++++
 tb/tb_iob_cache_write_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_write_buffer_pkg.sv
// Shared entry layout helpers for the write buffer: an entry is {addr, wdata, wstrb}, MSB first.
package iob_cache_write_buffer_pkg;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  localparam int STRB_LSB = 0;

  function automatic int data_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_cache_wbuf_regfile.sv
// Write-buffer storage: 2**DEPTH_W entries, one write port with per-byte enables, async read, no reset.
module iob_cache_wbuf_regfile
  import iob_cache_write_buffer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic                                     merge,
  input  logic [DEPTH_W-1:0]                       waddr,
  input  logic [DATA_W/8-1:0]                      byte_en,
  input  logic [entry_width(ADDR_W, DATA_W)-1:0]   wentry,
  input  logic [DEPTH_W-1:0]                       raddr,
  output logic [entry_width(ADDR_W, DATA_W)-1:0]   rentry
);

  localparam int ENTRY_W  = entry_width(ADDR_W, DATA_W);
  localparam int NB       = DATA_W / 8;
  localparam int DATA_LSB = data_lsb(DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  logic [ENTRY_W-1:0] mem [2**DEPTH_W];

  // A merge keeps the stored address and ORs the new strobes into the old ones.
  always_ff @(posedge clk) begin
    if (we) begin
      if (!merge) begin
        mem[waddr][ADDR_LSB +: ADDR_W] <= wentry[ADDR_LSB +: ADDR_W];
      end
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) begin
          mem[waddr][DATA_LSB + 8*b +: 8] <= wentry[DATA_LSB + 8*b +: 8];
        end
      end
      mem[waddr][STRB_LSB +: NB] <= merge ? (mem[waddr][STRB_LSB +: NB] | wentry[STRB_LSB +: NB])
                                          : wentry[STRB_LSB +: NB];
    end
  end

  assign rentry = mem[raddr];

endmodule

// File: rtl/iob_cache_write_buffer.sv
// Write-through buffer between cache front-end and memory back-end.
// Define IOB_CACHE_WBUF_MERGE_EN to coalesce writes to the youngest queued address.
module iob_cache_write_buffer
  import iob_cache_write_buffer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                wr_req_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_wdata_i,
  input  logic [DATA_W/8-1:0] wr_wstrb_i,
  output logic                wr_ack_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_W:0]    level_o,
  output logic                be_valid_o,
  output logic [ADDR_W-1:0]   be_addr_o,
  output logic [DATA_W-1:0]   be_wdata_o,
  output logic [DATA_W/8-1:0] be_wstrb_o,
  input  logic                be_ready_i
);

  localparam int ENTRY_W  = entry_width(ADDR_W, DATA_W);
  localparam int NB       = DATA_W / 8;
  localparam int DEPTH    = 2**DEPTH_W;
  localparam int LEVEL_W  = DEPTH_W + 1;
  localparam int DATA_LSB = data_lsb(DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               empty;
  logic               merge_hit;
  logic               push;
  logic               pop;
  logic               do_merge;
  logic               we;
  logic [DEPTH_W-1:0] waddr;
  logic [NB-1:0]      byte_en;
  logic [ENTRY_W-1:0] wentry;
  logic [ENTRY_W-1:0] head;

  assign full  = (level == LEVEL_W'(DEPTH));
  assign empty = (level == '0);

`ifdef IOB_CACHE_WBUF_MERGE_EN
  logic [ADDR_W-1:0] tail_addr;

  // Level >= 2 guarantees the youngest entry is not the head being offered to the back-end.
  assign merge_hit = wr_req_i && (level >= LEVEL_W'(2)) && (wr_addr_i == tail_addr);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tail_addr <= '0;
    end else if (push) begin
      tail_addr <= wr_addr_i;
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign wr_ack_o = wr_req_i & (~full | merge_hit);
  assign push     = wr_req_i & ~full & ~merge_hit & cke_i;
  assign do_merge = merge_hit & cke_i;
  assign pop      = ~empty & be_ready_i & cke_i;

  assign we      = push | do_merge;
  assign waddr   = do_merge ? (wr_ptr - DEPTH_W'(1)) : wr_ptr;
  assign byte_en = do_merge ? wr_wstrb_i : '1;
  assign wentry  = {wr_addr_i, wr_wdata_i, wr_wstrb_i};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  iob_cache_wbuf_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH_W(DEPTH_W)
  ) u_regfile (
    .clk    (clk_i),
    .we     (we),
    .merge  (do_merge),
    .waddr  (waddr),
    .byte_en(byte_en),
    .wentry (wentry),
    .raddr  (rd_ptr),
    .rentry (head)
  );

  // Storage is never reset, so the head fields are masked whenever nothing is queued.
  assign be_valid_o = ~empty;
  assign be_addr_o  = empty ? '0 : head[ADDR_LSB +: ADDR_W];
  assign be_wdata_o = empty ? '0 : head[DATA_LSB +: DATA_W];
  assign be_wstrb_o = empty ? '0 : head[STRB_LSB +: NB];

  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = level;

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Scoreboard bench for iob_cache_write_buffer: accepted writes queue expected back-end beats.
module tb_iob_cache_write_buffer;

  logic        clk;
  logic        arst_n;
  logic        cke;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        wr_ack;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        be_valid;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic [3:0]  be_wstrb;
  logic        be_ready;

  int vectors;
  int miscompares;

  logic [67:0] sb[$];
  logic [67:0] mon_exp;

  iob_cache_write_buffer #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH_W(2)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .cke_i     (cke),
    .wr_req_i  (wr_req),
    .wr_addr_i (wr_addr),
    .wr_wdata_i(wr_wdata),
    .wr_wstrb_i(wr_wstrb),
    .wr_ack_o  (wr_ack),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level),
    .be_valid_o(be_valid),
    .be_addr_o (be_addr),
    .be_wdata_o(be_wdata),
    .be_wstrb_o(be_wstrb),
    .be_ready_i(be_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle; caller is just past a rising edge.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic exp_ack, input logic store);
    wr_req   = 1'b1;
    wr_addr  = a;
    wr_wdata = d;
    wr_wstrb = s;
    @(negedge clk);
    check_output("wr_ack", 64'(wr_ack), 64'(exp_ack));
    if (store) sb.push_back({a, d, s});
    tick();
    wr_req = 1'b0;
  endtask

  // Monitor: every back-end handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (arst_n && cke && be_valid && be_ready) begin
      check_output("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check_output("be_addr", 64'(be_addr), 64'(mon_exp[67:36]));
        check_output("be_wdata", 64'(be_wdata), 64'(mon_exp[35:4]));
        check_output("be_wstrb", 64'(be_wstrb), 64'(mon_exp[3:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    arst_n   = 1'b0;
    cke      = 1'b1;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_wdata = '0;
    wr_wstrb = '0;
    be_ready = 1'b0;

    #12;
    check_output("rst_level", 64'(level), 64'd0);
    check_output("rst_empty", 64'(empty), 64'd1);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_be_valid", 64'(be_valid), 64'd0);
    check_output("rst_be_addr", 64'(be_addr), 64'd0);
    #10 arst_n = 1'b1;
    tick();

    $display("[TB] single push and drain");
    apply_stimulus(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    be_ready = 1'b1;
    @(negedge clk);
    check_output("t1_be_valid", 64'(be_valid), 64'd1);
    check_output("t1_level", 64'(level), 64'd1);
    tick();
    be_ready = 1'b0;
    @(negedge clk);
    check_output("t1_empty", 64'(empty), 64'd1);
    check_output("t1_be_wdata_zero", 64'(be_wdata), 64'd0);
    tick();

    $display("[TB] fill to full, blocked request, ordered drain");
    apply_stimulus(32'hA0, 32'hA5A50000, 4'h1, 1'b1, 1'b1);
    apply_stimulus(32'hA1, 32'hA5A50001, 4'h3, 1'b1, 1'b1);
    apply_stimulus(32'hA2, 32'hA5A50002, 4'hC, 1'b1, 1'b1);
    apply_stimulus(32'hA3, 32'hA5A50003, 4'h0, 1'b1, 1'b1);
    apply_stimulus(32'hA4, 32'hA5A50004, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t2_full", 64'(full), 64'd1);
    check_output("t2_level", 64'(level), 64'd4);
    tick();
    be_ready = 1'b1;
    repeat (4) tick();
    be_ready = 1'b0;
    @(negedge clk);
    check_output("t2_empty", 64'(empty), 64'd1);
    tick();

    $display("[TB] simultaneous push and pop at level 1");
    apply_stimulus(32'h30, 32'h33333333, 4'hF, 1'b1, 1'b1);
    be_ready = 1'b1;
    apply_stimulus(32'h40, 32'hCAFEF00D, 4'h5, 1'b1, 1'b1);
    be_ready = 1'b0;
    @(negedge clk);
    check_output("t3_level", 64'(level), 64'd1);
    check_output("t3_be_addr", 64'(be_addr), 64'h40);
    check_output("t3_be_valid", 64'(be_valid), 64'd1);
    tick();

    $display("[TB] async reset with entries queued");
    apply_stimulus(32'h60, 32'h66666666, 4'hF, 1'b1, 1'b1);
    apply_stimulus(32'h70, 32'h77777777, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    check_output("t4_level_pre", 64'(level), 64'd3);
    #2 arst_n = 1'b0;
    #1;
    check_output("t4_level", 64'(level), 64'd0);
    check_output("t4_empty", 64'(empty), 64'd1);
    check_output("t4_be_valid", 64'(be_valid), 64'd0);
    check_output("t4_be_addr", 64'(be_addr), 64'd0);
    check_output("t4_be_wstrb", 64'(be_wstrb), 64'd0);
    sb.delete();
    @(negedge clk);
    arst_n   = 1'b1;
    be_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("t4_no_valid", 64'(be_valid), 64'd0);
    end
    tick();
    be_ready = 1'b0;

    $display("[TB] clock enable low freezes state");
    apply_stimulus(32'h80, 32'h88888888, 4'h9, 1'b1, 1'b1);
    cke      = 1'b0;
    wr_req   = 1'b1;
    wr_addr  = 32'h90;
    wr_wdata = 32'h99999999;
    wr_wstrb = 4'hF;
    be_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_output("t5_level", 64'(level), 64'd1);
      check_output("t5_be_addr", 64'(be_addr), 64'h80);
      check_output("t5_ack", 64'(wr_ack), 64'd1);
    end
    tick();
    cke    = 1'b1;
    wr_req = 1'b0;
    tick();
    be_ready = 1'b0;
    @(negedge clk);
    check_output("t5_empty", 64'(empty), 64'd1);
    check_output("t5_level_end", 64'(level), 64'd0);
    tick();

`ifdef IOB_CACHE_WBUF_MERGE_EN
    $display("[TB] write coalescing into youngest entry");
    apply_stimulus(32'h50, 32'h55555555, 4'hF, 1'b1, 1'b1);
    apply_stimulus(32'h20, 32'h11223344, 4'h3, 1'b1, 1'b1);
    apply_stimulus(32'h20, 32'hAABBCCDD, 4'hC, 1'b1, 1'b0);
    sb[sb.size()-1] = {32'h20, 32'hAABB3344, 4'hF};
    @(negedge clk);
    check_output("t6_level", 64'(level), 64'd2);
    tick();
    be_ready = 1'b1;
    repeat (2) tick();
    be_ready = 1'b0;
    @(negedge clk);
    check_output("t6_empty", 64'(empty), 64'd1);
`endif

    check_output("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
